// File: rtl/spidergon_output_arbiter_pkg.sv
// Shared types and constants for the Spidergon output-port arbiter and its neighbours.
package spidergon_output_arbiter_pkg;

    localparam int unsigned PORT_LOCAL  = 0;
    localparam int unsigned PORT_CW     = 1;
    localparam int unsigned PORT_CCW    = 2;
    localparam int unsigned PORT_ACROSS = 3;

    // Flit-type bit positions, identical in the node buffers.
    localparam int unsigned FLIT_HEAD_BIT = 0;
    localparam int unsigned FLIT_TAIL_BIT = 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spidergon_output_arbiter_if.sv
// Request/grant/credit bundle between the input side of a router and one output arbiter.
interface spidergon_output_arbiter_if #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned NUM_VC  = 2,
    parameter int unsigned VCW     = 1,
    parameter int unsigned CW      = 2
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_head;
    logic [NUM_REQ-1:0]     req_tail;
    logic [NUM_REQ*VCW-1:0] req_vc;
    logic [NUM_VC-1:0]      credit_return;
    logic [NUM_REQ-1:0]     grant;
    logic                   grant_valid;
    logic [VCW-1:0]         grant_vc;
    logic                   locked;
    logic [NUM_VC*CW-1:0]   credit_count;
    logic                   err_credit_overflow;

    modport master (
        output req, req_head, req_tail, req_vc, credit_return,
        input  grant, grant_valid, grant_vc, locked, credit_count, err_credit_overflow
    );

    modport slave (
        input  req, req_head, req_tail, req_vc, credit_return,
        output grant, grant_valid, grant_vc, locked, credit_count, err_credit_overflow
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin: first requester strictly after ptr wins, wrapping around.
module rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] idx_o
);
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (PtrW'(i) > ptr_i)) begin
                gnt_o[i] = 1'b1;
                idx_o    = PtrW'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                idx_o    = PtrW'(i);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spidergon_output_arbiter.sv
// Wormhole output arbiter: round-robin packet grant, head-to-tail hold, per-VC credit tracking.
module spidergon_output_arbiter
    import spidergon_output_arbiter_pkg::*;
#(
    parameter int unsigned NUM_OF_INPUTS           = PORT_ACROSS + 1,
    parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int unsigned CREDITS_PER_VC          = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    spidergon_output_arbiter_if.slave arb
);
    localparam int unsigned NUM_REQ = NUM_OF_INPUTS * NUM_OF_VIRTUAL_CHANNELS;
    localparam int unsigned NUM_VC  = NUM_OF_VIRTUAL_CHANNELS;
    localparam int unsigned VCW     = idx_width(NUM_VC);
    localparam int unsigned CW      = $clog2(CREDITS_PER_VC + 1);
    localparam int unsigned PTRW    = idx_width(NUM_REQ);

    arb_state_e       state_q;
    logic [PTRW-1:0]  ptr_q, owner_q;
    logic [VCW-1:0]   owner_vc_q;
    logic [CW-1:0]    credit_q [NUM_VC];
    logic [CW-1:0]    credit_d [NUM_VC];
    logic             err_q, err_d;

    logic [NUM_VC-1:0]  credit_nz;
    logic [VCW-1:0]     vc_of [NUM_REQ];
    logic [NUM_REQ-1:0] eligible, idle_gnt, grant;
    logic [PTRW-1:0]    idle_idx, win_idx;
    logic [VCW-1:0]     grant_vc;
    logic               grant_valid, win_tail;

    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            credit_nz[v] = (credit_q[v] != '0);
        end
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            vc_of[r]    = arb.req_vc[r*VCW +: VCW];
            eligible[r] = arb.req[r] && arb.req_head[r] && (int'(vc_of[r]) < int'(NUM_VC)) &&
                          credit_nz[vc_of[r]];
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (idle_gnt),
        .idx_o (idle_idx)
    );

    always_comb begin
        grant    = '0;
        grant_vc = '0;
        win_idx  = idle_idx;
        if (!reset_i) begin
            if (state_q == ARB_IDLE) begin
                grant = idle_gnt;
                if (|idle_gnt) grant_vc = vc_of[idle_idx];
            end else begin
                // Mid-packet the owner's req_vc/req_head are don't-care.
                win_idx = owner_q;
                if (arb.req[owner_q] && credit_nz[owner_vc_q]) begin
                    grant[owner_q] = 1'b1;
                    grant_vc       = owner_vc_q;
                end
            end
        end
        grant_valid = |grant;
        win_tail    = arb.req_tail[win_idx];
    end

    always_comb begin
        err_d = err_q;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            credit_d[v] = credit_q[v];
            if (arb.credit_return[v] && !(grant_valid && grant_vc == VCW'(v))) begin
                if (credit_q[v] == CW'(CREDITS_PER_VC)) err_d = 1'b1;
                else credit_d[v] = credit_q[v] + CW'(1);
            end else if (!arb.credit_return[v] && grant_valid && grant_vc == VCW'(v)) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= PTRW'(NUM_REQ - 1);
            owner_q    <= '0;
            owner_vc_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned v = 0; v < NUM_VC; v++) credit_q[v] <= CW'(CREDITS_PER_VC);
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
            if (grant_valid) begin
                unique case (state_q)
                    ARB_IDLE: begin
                        ptr_q <= idle_idx;
                        if (!win_tail) begin
                            state_q    <= ARB_LOCKED;
                            owner_q    <= idle_idx;
                            owner_vc_q <= grant_vc;
                        end
                    end
                    ARB_LOCKED: begin
                        if (win_tail) state_q <= ARB_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        arb.grant               = grant;
        arb.grant_valid         = grant_valid;
        arb.grant_vc            = grant_vc;
        arb.locked              = (state_q == ARB_LOCKED) && !reset_i;
        arb.err_credit_overflow = err_q;
        for (int unsigned v = 0; v < NUM_VC; v++) arb.credit_count[v*CW +: CW] = credit_q[v];
    end
endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// Directed vector table plus a randomised packet/credit stream for the output arbiter.
module tb_spidergon_output_arbiter;
    import spidergon_output_arbiter_pkg::*;

    localparam int unsigned NI = 4, NV = 2, CR = 2, NR = 8, VCW = 1, CW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spidergon_output_arbiter_if #(.NUM_REQ(NR), .NUM_VC(NV), .VCW(VCW), .CW(CW)) bus ();

    spidergon_output_arbiter #(
        .NUM_OF_INPUTS           (NI),
        .NUM_OF_VIRTUAL_CHANNELS (NV),
        .CREDITS_PER_VC          (CR)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .arb     (bus)
    );

    typedef struct {
        logic       rst, chk;
        logic [7:0] req, head, tail, vc;
        logic [1:0] cret;
        logic [7:0] g;
        logic       gvc, lk;
        logic [3:0] cc;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic chk, input logic [7:0] req,
                                input logic [7:0] head, input logic [7:0] tail,
                                input logic [7:0] vc, input logic [1:0] cret, input logic [7:0] g,
                                input logic gvc, input logic lk, input logic [3:0] cc,
                                input logic err);
        vec_t v;
        v.rst = rst; v.chk = chk; v.req = req; v.head = head; v.tail = tail; v.vc = vc;
        v.cret = cret; v.g = g; v.gvc = gvc; v.lk = lk; v.cc = cc; v.err = err;
        vecs.push_back(v);
    endfunction

    // Random-phase model state.
    int         act [NR], pos [NR], len [NR], wcnt [NR];
    logic [7:0] pvc;
    int         occ [NV];
    int         owner;
    logic [7:0] r_req, r_head, r_tail, elig;
    logic [1:0] r_cret;

    initial begin
        vec_t e;
        int   w;
        logic [7:0] g;
        bus.req = '0; bus.req_head = '0; bus.req_tail = '0; bus.req_vc = '0;
        bus.credit_return = '0;

        // credit_count packs {vc1, vc0}: 4'hA = 2/2, 4'h9 = vc0 at 1, 4'h8 = vc0 at 0.
        // 1: r0/r5 single flits on vc0, credits returned every cycle.
        add(0, 1, 8'h21, 8'h21, 8'h21, 8'h00, 2'b01, 8'h01, 0, 0, 4'hA, 0);
        add(0, 1, 8'h21, 8'h21, 8'h21, 8'h00, 2'b01, 8'h20, 0, 0, 4'hA, 0);
        add(0, 1, 8'h21, 8'h21, 8'h21, 8'h00, 2'b01, 8'h01, 0, 0, 4'hA, 0);
        add(0, 1, 8'h21, 8'h21, 8'h21, 8'h00, 2'b01, 8'h20, 0, 0, 4'hA, 0);
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 0);
        // 2: r2 4-flit packet on vc1 holds the output against r3's head on vc0.
        add(0, 1, 8'h0C, 8'h0C, 8'h08, 8'h04, 2'b10, 8'h04, 1, 0, 4'hA, 0);
        add(0, 1, 8'h0C, 8'h08, 8'h08, 8'h04, 2'b10, 8'h04, 1, 1, 4'hA, 0);
        add(0, 1, 8'h0C, 8'h08, 8'h08, 8'h04, 2'b10, 8'h04, 1, 1, 4'hA, 0);
        add(0, 1, 8'h0C, 8'h08, 8'h0C, 8'h04, 2'b10, 8'h04, 1, 1, 4'hA, 0);
        add(0, 1, 8'h08, 8'h08, 8'h08, 8'h00, 2'b00, 8'h08, 0, 0, 4'hA, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'h9, 0);
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 0);
        // 3: r1 streams vc0 with no returns; one return buys exactly one more flit.
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b00, 8'h02, 0, 0, 4'hA, 0);
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b00, 8'h02, 0, 0, 4'h9, 0);
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b00, 8'h00, 0, 0, 4'h8, 0);
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b01, 8'h00, 0, 0, 4'h8, 0);
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b00, 8'h02, 0, 0, 4'h9, 0);
        add(0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 2'b00, 8'h00, 0, 0, 4'h8, 0);
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 0);
        // 4: grant+return on vc1 cancel; return on full vc0 sets the sticky error.
        add(0, 1, 8'h10, 8'h10, 8'h10, 8'h10, 2'b10, 8'h10, 1, 0, 4'hA, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 0, 0, 4'hA, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 1);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 1);
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'hA, 0);
        // 5: reset while locked by r6, then everyone requests: r0 first.
        add(0, 1, 8'h40, 8'h40, 8'h00, 8'h00, 2'b00, 8'h40, 0, 0, 4'hA, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 1, 4'h9, 0);
        add(1, 1, 8'h40, 8'h40, 8'h40, 8'h00, 2'b00, 8'h00, 0, 0, 4'h9, 0);
        add(0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'b00, 8'h01, 0, 0, 4'hA, 0);
        // Body-only request while idle is ignored.
        add(0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 4'h9, 0);

        repeat (3) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            reset = vecs[i].rst;
            bus.req = vecs[i].req; bus.req_head = vecs[i].head; bus.req_tail = vecs[i].tail;
            bus.req_vc = vecs[i].vc; bus.credit_return = vecs[i].cret;
            if (vecs[i].chk) sb.push_back(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                e = sb.pop_front();
                check($sformatf("v%0d grant", i), 32'(bus.grant), 32'(e.g));
                check($sformatf("v%0d grant_valid", i), 32'(bus.grant_valid), 32'(|e.g));
                check($sformatf("v%0d grant_vc", i), 32'(bus.grant_vc), 32'(e.gvc));
                check($sformatf("v%0d locked", i), 32'(bus.locked), 32'(e.lk));
                check($sformatf("v%0d credit_count", i), 32'(bus.credit_count), 32'(e.cc));
                check($sformatf("v%0d err", i), 32'(bus.err_credit_overflow), 32'(e.err));
            end
            @(posedge clk);
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Random packet streams against a downstream-buffer occupancy model.
        #1;
        reset = 1'b1;
        bus.req = '0; bus.req_head = '0; bus.req_tail = '0; bus.credit_return = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        owner = -1;
        pvc = '0;
        for (int r = 0; r < NR; r++) begin act[r] = 0; pos[r] = 0; len[r] = 1; wcnt[r] = 0; end
        for (int v = 0; v < NV; v++) occ[v] = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int r = 0; r < NR; r++) begin
                if (act[r] == 0 && $urandom_range(3) == 0) begin
                    act[r] = 1; pos[r] = 0; len[r] = int'($urandom_range(4, 1));
                    pvc[r] = 1'($urandom_range(1));
                end
                r_req[r]  = (act[r] != 0) && ($urandom_range(7) != 0);
                r_head[r] = (pos[r] == 0);
                r_tail[r] = (pos[r] == len[r] - 1);
            end
            for (int v = 0; v < NV; v++) r_cret[v] = (occ[v] > 0) && ($urandom_range(2) != 0);
            bus.req = r_req; bus.req_head = r_head; bus.req_tail = r_tail;
            bus.req_vc = pvc; bus.credit_return = r_cret;
            @(negedge clk);
            g = bus.grant;
            for (int r = 0; r < NR; r++)
                elig[r] = r_req[r] && r_head[r] && (CR - occ[pvc[r]] != 0);
            check("rnd onehot0", 32'($onehot0(g)), 32'd1);
            check("rnd locked", 32'(bus.locked), 32'(owner >= 0));
            check("rnd err", 32'(bus.err_credit_overflow), 32'd0);
            for (int v = 0; v < NV; v++)
                check($sformatf("rnd credit vc%0d", v), 32'(bus.credit_count[v*CW +: CW]),
                      32'(CR - occ[v]));
            if (owner < 0)
                check("rnd work-conserving idle", 32'(|g), 32'(|elig));
            else
                check("rnd owner progress", 32'(|g),
                      32'(r_req[owner] && (CR - occ[pvc[owner]] != 0)));
            if (|g) begin
                w = 0;
                for (int r = 0; r < NR; r++) if (g[r]) w = r;
                check("rnd grant has req", 32'(r_req[w]), 32'd1);
                check("rnd grant_vc", 32'(bus.grant_vc), 32'(pvc[w]));
                check("rnd credit at grant", 32'(CR - occ[pvc[w]] != 0), 32'd1);
                if (owner >= 0) begin
                    check("rnd no interleave", 32'(w), 32'(owner));
                end else begin
                    check("rnd idle grant is head", 32'(r_head[w]), 32'd1);
                    for (int r = 0; r < NR; r++) begin
                        if (r == w) wcnt[r] = 0;
                        else if (elig[r]) begin
                            wcnt[r]++;
                            check($sformatf("rnd starve r%0d", r), 32'(wcnt[r] <= NR), 32'd1);
                        end else wcnt[r] = 0;
                    end
                end
                if (r_tail[w]) owner = -1;
                else if (r_head[w]) owner = w;
                occ[pvc[w]]++;
                pos[w]++;
                if (pos[w] == len[w]) act[w] = 0;
            end
            for (int v = 0; v < NV; v++) occ[v] -= int'(r_cret[v]);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
